meta_sync_xfer_ctrl: RTL
========================

// Module: meta_sync_xfer_ctrl
// PURPOSE
//  Source-side sequencer for a bundled-data, two-phase (toggle) clock-domain crossing in the MAC.
//  Accepts one DATA_W word per handshake, holds it stable on xfer_data and toggles xfer_req.
//  Completes when the far domain echoes the toggle back on xfer_ack_async.
//  Far side samples xfer_req through its own single-bit synchronizer; this block owns the local ack synchronizer.
// PARAMETERS
//  DATA_W       32    width of transferred word
//  SYNC_STAGES  2     flops in local ack synchronizer (>=2)
//  TIMEOUT_CYC  1024  WAIT_ACK cycles before timeout (used only with META_SYNC_XFER_TIMEOUT_EN)
// PORTS
//  clk             in   1       single clock; all logic on posedge
//  reset           in   1       synchronous, active-high reset
//  src_valid       in   1       requester has word on src_data
//  src_data        in   DATA_W  word to transfer
//  src_ready       out  1       controller accepts word this cycle
//  xfer_data       out  DATA_W  held word to far domain, stable while busy
//  xfer_req        out  1       request toggle to far domain (registered, glitch-free)
//  xfer_ack_async  in   1       ack toggle from far domain, asynchronous to clk
//  xfer_done       out  1       1-cycle pulse on completion
//  busy            out  1       high in any state except IDLE
//  timeout_err     out  1       1-cycle pulse on timeout (tied 0 without macro)
// BEHAVIOUR
//  Reset: xfer_req=0, xfer_data=0, src_ready=0, xfer_done=0, timeout_err=0, busy=1, ack sync flops=0, state=INIT.
//  ack_s = last stage of ack synchronizer; "in step" means ack_s == xfer_req.
//  INIT: counts SYNC_STAGES+1 cycles to flush synchronizer; then in step -> IDLE, else -> RECOVER.
//  IDLE: src_ready=1 (combinational from state). src_valid&&src_ready -> xfer_data<=src_data,
//    xfer_req<=~xfer_req, -> WAIT_ACK. src_data ignored without src_valid.
//  WAIT_ACK: src_ready=0; xfer_data, xfer_req frozen. In step -> xfer_done=1 next cycle, -> IDLE.
//    Next word accepted earliest the cycle after xfer_done (no back-to-back accept).
//  RECOVER: src_ready=0; waits until in step, -> IDLE; no xfer_done.
//  Round trip: accept -> done >= far-side sync latency + SYNC_STAGES + 1 cycles.
//  Ack toggle while IDLE (far side out of step): -> RECOVER the next cycle; src_ready drops.
//  Reset mid-WAIT_ACK: transfer abandoned, no xfer_done; far side must also be reset.
//    A non-zero ack after INIT routes via RECOVER.
//  Only xfer_ack_async crosses domains; it feeds the synchronizer alone, never raw logic.
// CONFIGURATION
//  META_SYNC_XFER_TIMEOUT_EN defined: counter of width $clog2(TIMEOUT_CYC+1) clears on WAIT_ACK entry.
//    It increments each WAIT_ACK cycle. At TIMEOUT_CYC without in step: timeout_err=1 for one cycle,
//    -> RECOVER (late ack then resyncs).
//    Ack arriving on the same cycle the count reaches TIMEOUT_CYC wins: done, no error.
//  Undefined: no counter, WAIT_ACK waits indefinitely, timeout_err tied 0.
// STRUCTURE
//  Package meta_sync_xfer_pkg: state encoding ST_INIT/ST_IDLE/ST_WAIT_ACK/ST_RECOVER (2-bit), default widths.
//  Sub-module meta_sync_xfer_ack_sync: SYNC_STAGES-deep flop chain, sync active-high reset to 0.
//  Top: FSM, data/toggle registers, INIT counter, optional timeout counter.
// TESTING
//  Reset, ack held 0 -> busy=1 for SYNC_STAGES+1 cycles, then src_ready=1, xfer_req=0.
//  Accept 0xDEADBEEF; bench echoes xfer_req to ack after 5 cycles -> xfer_req=1, xfer_data stable, xfer_done 1 pulse at accept+5+SYNC_STAGES+1.
//  src_valid held high, 4 words 0x1..0x4 -> exactly 4 accepts, xfer_req toggles 4x, 4 xfer_done pulses, order kept.
//  Ack toggled while IDLE -> src_ready=0 in RECOVER; ack toggled back -> IDLE, no done/err.
//  Macro on, TIMEOUT_CYC=16, ack never returns -> timeout_err at WAIT_ACK cycle 16; late ack -> IDLE.
//  Reset asserted mid-WAIT_ACK, ack left at 1 -> INIT -> RECOVER, no xfer_done until ack returns to 0.

Source files
------------

// File: rtl/meta_sync_xfer_pkg.sv
// ----------------------------------------------------------------------------
// Package: meta_sync_xfer_pkg
// Purpose : Shared definitions for the source-side toggle-handshake CDC
//           sequencer (meta_sync_xfer_ctrl) and its ack synchronizer.
// Contents:
//   state_t              - 2-bit FSM state encoding
//   DEFAULT_DATA_W       - default transferred word width
//   DEFAULT_SYNC_STAGES  - default depth of the local ack synchronizer
//   DEFAULT_TIMEOUT_CYC  - default WAIT_ACK timeout (optional feature,
//                          enabled by META_SYNC_XFER_TIMEOUT_EN)
// ----------------------------------------------------------------------------
package meta_sync_xfer_pkg;

  // Sequencer states. INIT flushes the synchronizer after reset, RECOVER
  // parks the controller until the far side's toggle agrees with ours.
  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_IDLE     = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RECOVER  = 2'd3
  } state_t;

  localparam int DEFAULT_DATA_W      = 32;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_TIMEOUT_CYC = 1024;

endpackage : meta_sync_xfer_pkg

// File: rtl/meta_sync_xfer_ack_sync.sv
// ----------------------------------------------------------------------------
// Module : meta_sync_xfer_ack_sync
// Purpose: Multi-flop synchronizer that brings the far domain's ack toggle
//          into the local clock domain. This is the only place the raw
//          asynchronous ack is allowed to land.
// Params : SYNC_STAGES - number of flops in the chain (must be >= 2)
// Ports  :
//   clk       in  1  local clock
//   reset     in  1  synchronous active-high reset, clears the chain to 0
//   ack_async in  1  ack toggle from the far domain (asynchronous)
//   ack_s     out 1  synchronized ack (last stage of the chain)
// ----------------------------------------------------------------------------
module meta_sync_xfer_ack_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ack_async,
  output logic ack_s
);

  logic [SYNC_STAGES-1:0] chain;

  // Plain shift chain: the asynchronous input enters bit 0 and is only
  // consumed by the rest of the design after SYNC_STAGES flops, giving any
  // metastability in the first stage a full cycle per stage to resolve.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], ack_async};
    end
  end

  assign ack_s = chain[SYNC_STAGES-1];

endmodule : meta_sync_xfer_ack_sync

// File: rtl/meta_sync_xfer_ctrl.sv
// ----------------------------------------------------------------------------
// Module : meta_sync_xfer_ctrl
// Purpose: Source-side sequencer for a bundled-data, two-phase (toggle)
//          clock-domain crossing. One word is accepted per handshake, held
//          stable on xfer_data while xfer_req is toggled; the transfer ends
//          when the far domain echoes the toggle back on xfer_ack_async.
// Params :
//   DATA_W       width of the transferred word
//   SYNC_STAGES  flops in the local ack synchronizer (>= 2)
//   TIMEOUT_CYC  WAIT_ACK cycles before giving up (timeout build only)
// Config :
//   META_SYNC_XFER_TIMEOUT_EN - when defined, a WAIT_ACK watchdog raises
//   timeout_err and moves to RECOVER; otherwise WAIT_ACK waits forever and
//   timeout_err is tied low.
// Ports  :
//   clk             in  1       single clock, posedge
//   reset           in  1       synchronous active-high reset
//   src_valid       in  1       requester has a word on src_data
//   src_data        in  DATA_W  word to transfer
//   src_ready       out 1       word accepted this cycle when valid
//   xfer_data       out DATA_W  held word, stable while busy
//   xfer_req        out 1       registered request toggle to far domain
//   xfer_ack_async  in  1       ack toggle from far domain (async)
//   xfer_done       out 1       one-cycle pulse on completion
//   busy            out 1       high in every state except IDLE
//   timeout_err     out 1       one-cycle pulse on timeout
// ----------------------------------------------------------------------------
module meta_sync_xfer_ctrl
  import meta_sync_xfer_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic [DATA_W-1:0] xfer_data,
  output logic              xfer_req,
  input  logic              xfer_ack_async,
  output logic              xfer_done,
  output logic              busy,
  output logic              timeout_err
);

  // INIT lasts SYNC_STAGES+1 cycles: enough for a post-reset ack level to
  // reach the end of the synchronizer before we judge whether we are in step.
  localparam int                INIT_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES);

  state_t            state;
  logic [INIT_W-1:0] init_cnt;
  logic              ack_s;
  logic              in_step;
  logic              accept;
  logic              timeout_hit;

  meta_sync_xfer_ack_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk       (clk),
    .reset     (reset),
    .ack_async (xfer_ack_async),
    .ack_s     (ack_s)
  );

  // The two toggles agree when the far side has seen (and echoed) every
  // request we have issued; this is the only completion criterion.
  assign in_step   = (ack_s == xfer_req);
  assign src_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = src_valid && src_ready;

`ifdef META_SYNC_XFER_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt;
  logic            timeout_q;

  // The watchdog fires on the TIMEOUT_CYC-th WAIT_ACK cycle, but only if the
  // ack is still out of step; an ack landing on that same cycle wins.
  assign timeout_hit = (state == ST_WAIT_ACK) && !in_step && (to_cnt == TO_LAST);

  // Watchdog counter: cleared as a word is accepted (i.e. on WAIT_ACK entry),
  // counts every WAIT_ACK cycle, and registers the one-cycle error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (accept) begin
        to_cnt <= '0;
      end else if (state == ST_WAIT_ACK) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

  assign timeout_err = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout_hit        = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  // Main sequencer. Accepting a word has priority in IDLE because src_ready
  // is already high there and the requester treats valid&&ready as taken.
  // An out-of-step ack seen in IDLE means the far side toggled on its own
  // (or is left over from a reset), so we park in RECOVER until it settles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      xfer_req  <= 1'b0;
      xfer_data <= '0;
      xfer_done <= 1'b0;
    end else begin
      xfer_done <= 1'b0;
      case (state)
        ST_INIT: begin
          if (init_cnt == INIT_LAST) begin
            state <= in_step ? ST_IDLE : ST_RECOVER;
          end else begin
            init_cnt <= init_cnt + INIT_W'(1);
          end
        end
        ST_IDLE: begin
          if (accept) begin
            xfer_data <= src_data;
            xfer_req  <= ~xfer_req;
            state     <= ST_WAIT_ACK;
          end else if (!in_step) begin
            state <= ST_RECOVER;
          end
        end
        ST_WAIT_ACK: begin
          if (in_step) begin
            xfer_done <= 1'b1;
            state     <= ST_IDLE;
          end else if (timeout_hit) begin
            state <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          if (in_step) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule : meta_sync_xfer_ctrl
